// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the DRAM front-end arbiter.
// Imported by the arbiter top and its round-robin select.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_MEM_WORDS = 1025;

    // Index width for n requesters, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_arbiter_rr.sv
// Rotating-priority select: the first requester after ptr wins.
// Purely combinational; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    localparam logic [IW:0] NV = (IW+1)'(N);

    logic [IW:0]   sum;
    logic [IW-1:0] c;
    logic          found;

    assign any = |req;

    // Walk ptr+1 .. ptr+N (mod N) and keep the first active request.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        c     = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= NV) begin
                sum = sum - NV;
            end
            c = sum[IW-1:0];
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = c;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Multi-core round-robin front end for a single-port DRAM
// with registered read data; one transfer in flight at a time.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [NUM_CORES-1:0]        core_err,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        busy,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IW = idx_w(NUM_CORES);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS);

    state_t                 state;
    logic [IW-1:0]          ptr;
    logic [NUM_CORES-1:0]   gnt;
    logic [NUM_CORES-1:0]   g_gnt;
    logic [IW-1:0]          gidx;
    logic                   any_req;
    logic                   g_we;
    logic                   g_oor;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic                   sel_we;
    logic                   sel_in_range;

    rr_arbiter #(
        .N  (NUM_CORES),
        .IW (IW)
    ) u_rr (
        .req (core_req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (any_req)
    );

    // Pick the granted core's operation out of the flattened buses.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (gnt[i]) begin
                sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = core_wdata[i*DATA_W +: DATA_W];
                sel_we    = core_we[i];
            end
        end
    end

    assign sel_in_range = ({1'b0, sel_addr} < LIMIT);

    // Transfer FSM; every core- and DRAM-facing output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= IW'(NUM_CORES - 1);
            g_gnt      <= '0;
            g_we       <= 1'b0;
            g_oor      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_ack   <= '0;
            core_err   <= '0;
            core_rdata <= '0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    core_ack   <= '0;
                    core_err   <= '0;
                    core_rdata <= '0;
                    mem_we     <= 1'b0;
                    if (any_req) begin
                        g_gnt     <= gnt;
                        g_we      <= sel_we;
                        g_oor     <= !sel_in_range;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_we    <= sel_we & sel_in_range;
                        ptr       <= gidx;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    if (g_we || g_oor) begin
                        core_ack   <= g_gnt;
                        core_err   <= g_oor ? g_gnt : '0;
                        core_rdata <= '0;
                        state      <= RESP;
                    end else begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    core_rdata <= mem_rdata;
                    core_ack   <= g_gnt;
                    core_err   <= '0;
                    state      <= RESP;
                end
                RESP: begin
                    core_ack   <= '0;
                    core_err   <= '0;
                    core_rdata <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Multi-core front end for the shared single-port DRAM. The DRAM has a 16-bit address, 16-bit data, 1025 words, and registered read data, one cycle after the address.
- Accepts independent req/ack requests from NUM_CORES cores and grants one core at a time in round-robin order.
- Drives the DRAM write_en/addr/data_in pins, captures data_out, and returns the read data and ack to the granted core.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_WORDS, 1025, valid DRAM address range is 0..MEM_WORDS-1.

Ports:
- clk  in  1  single clock, shared with the DRAM.
- rst_n  in  1  reset, asynchronous, active-low.
- core_req  in  NUM_CORES  per-core request; held high until ack.
- core_we  in  NUM_CORES  per-core op: 1 = write, 0 = read.
- core_addr  in  NUM_CORES*ADDR_W  flattened; core i uses bits [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  flattened write data.
- core_ack  out  NUM_CORES  one-cycle completion pulse to the granted core.
- core_err  out  NUM_CORES  one-cycle pulse alongside ack when the address is out of range.
- core_rdata  out  DATA_W  read data, shared bus; valid only while the matching core_ack is high.
- busy  out  1  high in every state except IDLE.
- mem_we  out  1  to DRAM write_en.
- mem_addr  out  ADDR_W  to DRAM addr.
- mem_wdata  out  DATA_W  to DRAM data_in.
- mem_rdata  in  DATA_W  from DRAM data_out.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - core_ack=0, core_err=0, core_rdata=0, busy=0.
  - rr pointer=NUM_CORES-1, so core 0 has first priority.
- Reset mid-operation aborts the transfer with no ack. If reset is asserted before the DRAM sampling edge, mem_we drops at once and the write is lost.
- All outputs are registered. mem_we is 1 only in ACCESS for an in-range write.
- FSM states:
  - IDLE: if any core_req is high, select the first requester after the rr pointer (wrapping). Latch its index, we, addr and wdata. Load mem_addr/mem_wdata. Load mem_we = we & in-range. Update the pointer to the granted index. Go to ACCESS. With no request, stay in IDLE and hold mem_we=0.
  - ACCESS: mem_* stay stable; the DRAM samples at the end of this cycle. Clear mem_we on exit. A read goes to RDWAIT; a write or an out-of-range access goes to RESP.
  - RDWAIT: mem_rdata is now valid; capture it into an rdata register. Go to RESP.
  - RESP: core_ack[g]=1 for exactly one cycle. core_rdata = captured data for a read, 0 for a write or out-of-range access. core_err[g]=1 if out of range. Go to IDLE.
- Out-of-range means addr >= MEM_WORDS: the DRAM is never written, the read returns 0, err is pulsed.
- Latency, counting cycle 0 as the IDLE cycle in which req is seen:
  - write: ack in cycle 2.
  - read: ack plus data in cycle 3.
  - Throughput: one access per 3 cycles (write) or 4 cycles (read).
- Core rules:
  - A core holds req, we, addr and wdata stable from request until ack.
  - req must be low in the cycle after ack; otherwise it counts as a new request.
- Requests arriving while busy wait; no request is dropped.
- Simultaneous requests are resolved by round robin. Every requester is served within NUM_CORES grants.
- A core_req change of a non-granted core during a transfer has no effect on that transfer.

Decomposition:
- Package dram_arb_pkg contains:
  - state enum {IDLE, ACCESS, RDWAIT, RESP}, 2 bits.
  - default ADDR_W/DATA_W.
  - MEM_WORDS=1025.
- Sub-module rr_arbiter: combinational rotate-priority select from req plus pointer. Outputs a one-hot grant and a binary index. Pointer register in the parent.

Test Plan:
- Single write then read, core 1: write addr 10 data 85; read addr 10 -> write ack at cycle 2, read ack at cycle 3 with core_rdata=85; mem_we high for exactly one cycle.
- All four cores request a read in the same cycle after reset -> grants in order 0,1,2,3; each ack one-hot; no overlap.
- Fairness with core 0 and core 2 both requesting continuously -> grants alternate 0,2,0,2; core 2 never waits more than one transfer.
- Out of range: write addr 1025 data 0xFFFF, then read addr 1025 -> mem_we stays 0; both acks carry err=1; read data 0; addr 1024 still accepted.
- Back-to-back: core 3 writes 0x1234 to addr 0 and core 0 then reads addr 0 -> 0x1234; busy drops for exactly one IDLE cycle between accesses.
- Reset asserted during ACCESS of a write to addr 5 (old value 7) -> mem_we falls asynchronously; no ack; a later read of addr 5 returns 7.
